// File: rtl/nim_game_ctrl_if.sv
// Button pulses into the Nim controller and the game status it reports.
interface nim_game_ctrl_if;
    logic       start;
    logic       sel_next;
    logic       inc;
    logic       dec;
    logic       confirm;
    logic [3:0] heap0;
    logic [3:0] heap1;
    logic [3:0] heap2;
    logic [3:0] heap3;
    logic [1:0] sel_heap;
    logic [3:0] take_amt;
    logic       player;
    logic       winner_valid;
    logic       winner;
    logic       illegal;
    logic       motor_stop;
    logic       motor_dir;
    logic [2:0] state;

    // Button source / status observer
    modport master (
        output start, sel_next, inc, dec, confirm,
        input  heap0, heap1, heap2, heap3, sel_heap, take_amt, player,
               winner_valid, winner, illegal, motor_stop, motor_dir, state
    );

    // Game controller
    modport slave (
        input  start, sel_next, inc, dec, confirm,
        output heap0, heap1, heap2, heap3, sel_heap, take_amt, player,
               winner_valid, winner, illegal, motor_stop, motor_dir, state
    );
endinterface

// File: rtl/nim_game_ctrl.sv
// Nim turn sequencer: heap bookkeeping, move validation, win detection and motor hold.
module nim_game_ctrl #(
    parameter logic [15:0] INIT_HEAPS = 16'h3457,
    parameter logic [31:0] WIN_HOLD   = 32'd100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    nim_game_ctrl_if.slave    bus
);

    localparam int unsigned HEAP_W = 4;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_APPLY  = 3'd2,
        S_CHECK  = 3'd3,
        S_WIN    = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0][HEAP_W-1:0]       heap_q, heap_d;
    logic [1:0]                   sel_q, sel_d;
    logic [HEAP_W-1:0]            take_q, take_d;
    logic                         player_q, player_d;
    logic                         winner_q, winner_d;
    logic                         win_valid_q, win_valid_d;
    logic                         illegal_q, illegal_d;
    logic                         mstop_q, mstop_d;
    logic                         mdir_q, mdir_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [HEAP_W-1:0]            cur_heap;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            heap_q      <= INIT_HEAPS;
            sel_q       <= 2'd0;
            take_q      <= HEAP_W'(1);
            player_q    <= 1'b0;
            winner_q    <= 1'b0;
            win_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            mstop_q     <= 1'b1;
            mdir_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            heap_q      <= heap_d;
            sel_q       <= sel_d;
            take_q      <= take_d;
            player_q    <= player_d;
            winner_q    <= winner_d;
            win_valid_q <= win_valid_d;
            illegal_q   <= illegal_d;
            mstop_q     <= mstop_d;
            mdir_q      <= mdir_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic; start overrides everything, otherwise one pulse by priority
    always_comb begin
        state_d     = state_q;
        heap_d      = heap_q;
        sel_d       = sel_q;
        take_d      = take_q;
        player_d    = player_q;
        winner_d    = winner_q;
        win_valid_d = win_valid_q;
        illegal_d   = 1'b0;
        mstop_d     = mstop_q;
        mdir_d      = mdir_q;
        cnt_d       = cnt_q;
        cur_heap    = heap_q[sel_q];

        if (bus.start) begin
            heap_d      = INIT_HEAPS;
            sel_d       = 2'd0;
            take_d      = HEAP_W'(1);
            player_d    = 1'b0;
            win_valid_d = 1'b0;
            mstop_d     = 1'b1;
            cnt_d       = '0;
            state_d     = S_SELECT;
        end else begin
            case (state_q)
                S_SELECT: begin
                    if (bus.confirm) begin
                        if (cur_heap == '0) illegal_d = 1'b1;
                        else                state_d   = S_APPLY;
                    end else if (bus.sel_next) begin
                        sel_d  = sel_q + 2'd1;
                        take_d = HEAP_W'(1);
                    end else if (bus.inc) begin
                        if (take_q < cur_heap) take_d = take_q + HEAP_W'(1);
                    end else if (bus.dec) begin
                        if (take_q > HEAP_W'(1)) take_d = take_q - HEAP_W'(1);
                    end
                end
                S_APPLY: begin
                    heap_d[sel_q] = cur_heap - take_q;
                    state_d       = S_CHECK;
                end
                S_CHECK: begin
                    if (heap_q == '0) begin
                        state_d     = S_WIN;
                        winner_d    = player_q;
                        win_valid_d = 1'b1;
                        mdir_d      = player_q;
                        mstop_d     = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        player_d = ~player_q;
                        take_d   = HEAP_W'(1);
                        state_d  = S_SELECT;
                    end
                end
                S_WIN: begin
                    if (!mstop_q) begin
                        if (cnt_q == WIN_HOLD - 32'd1) mstop_d = 1'b1;
                        else                           cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Registered status onto the bus
    assign bus.heap0        = heap_q[0];
    assign bus.heap1        = heap_q[1];
    assign bus.heap2        = heap_q[2];
    assign bus.heap3        = heap_q[3];
    assign bus.sel_heap     = sel_q;
    assign bus.take_amt     = take_q;
    assign bus.player       = player_q;
    assign bus.winner_valid = win_valid_q;
    assign bus.winner       = winner_q;
    assign bus.illegal      = illegal_q;
    assign bus.motor_stop   = mstop_q;
    assign bus.motor_dir    = mdir_q;
    assign bus.state        = 3'(state_q);

endmodule

// File: tb/tb_nim_game_ctrl.sv
// Directed bench for nim_game_ctrl with a move-level reference model checked every cycle.
module tb_nim_game_ctrl;

    localparam int WIN_HOLD = 8;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_checks;
    int   n_pass;

    nim_game_ctrl_if bus();

    nim_game_ctrl #(
        .INIT_HEAPS(16'h3457),
        .WIN_HOLD  (32'd8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the game in terms of moves in flight and win age
    int  init_heaps [4] = '{7, 5, 4, 3};
    int  m_heap [4];
    int  m_sel, m_take, m_player, m_winner, m_dir, m_age, m_win_age;
    bit  m_started, m_won, m_ill;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_heap[k] = init_heaps[k];
        m_sel = 0; m_take = 1; m_player = 0; m_winner = 0; m_dir = 0;
        m_age = 0; m_win_age = 0; m_started = 0; m_won = 0; m_ill = 0;
    endtask

    function automatic int m_state();
        if (!m_started) return 0;
        if (m_won)      return 4;
        if (m_age == 1) return 2;
        if (m_age == 2) return 3;
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ill = 0;
            if (bus.start) begin
                for (int k = 0; k < 4; k++) m_heap[k] = init_heaps[k];
                m_sel = 0; m_take = 1; m_player = 0; m_age = 0;
                m_started = 1; m_won = 0; m_win_age = 0;
            end else if (m_won) begin
                if (m_win_age < WIN_HOLD) m_win_age++;
            end else if (m_age == 1) begin
                m_heap[m_sel] -= m_take;
                m_age = 2;
            end else if (m_age == 2) begin
                if (m_heap[0] + m_heap[1] + m_heap[2] + m_heap[3] == 0) begin
                    m_won = 1; m_winner = m_player; m_dir = m_player; m_win_age = 0;
                end else begin
                    m_player ^= 1; m_take = 1;
                end
                m_age = 0;
            end else if (m_started) begin
                if (bus.confirm) begin
                    if (m_heap[m_sel] == 0) m_ill = 1;
                    else                    m_age = 1;
                end else if (bus.sel_next) begin
                    m_sel = (m_sel + 1) % 4; m_take = 1;
                end else if (bus.inc) begin
                    if (m_take < m_heap[m_sel]) m_take++;
                end else if (bus.dec) begin
                    if (m_take > 1) m_take--;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",        int'(bus.state),        m_state());
            chk("heap0",        int'(bus.heap0),        m_heap[0]);
            chk("heap1",        int'(bus.heap1),        m_heap[1]);
            chk("heap2",        int'(bus.heap2),        m_heap[2]);
            chk("heap3",        int'(bus.heap3),        m_heap[3]);
            chk("sel_heap",     int'(bus.sel_heap),     m_sel);
            chk("take_amt",     int'(bus.take_amt),     m_take);
            chk("player",       int'(bus.player),       m_player);
            chk("winner_valid", int'(bus.winner_valid), int'(m_won));
            chk("winner",       int'(bus.winner),       m_winner);
            chk("illegal",      int'(bus.illegal),      int'(m_ill));
            chk("motor_stop",   int'(bus.motor_stop),   int'(!(m_won && m_win_age < WIN_HOLD)));
            chk("motor_dir",    int'(bus.motor_dir),    m_dir);
        end
    end

    task automatic pulse(input bit s, input bit sn, input bit i, input bit d, input bit c);
        bus.start = s; bus.sel_next = sn; bus.inc = i; bus.dec = d; bus.confirm = c;
        @(negedge clk);
        bus.start = 0; bus.sel_next = 0; bus.inc = 0; bus.dec = 0; bus.confirm = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_move(input int nsel, input int ninc);
        repeat (nsel) pulse(0, 1, 0, 0, 0);
        repeat (ninc) pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 1);
        idle(2);
    endtask

    initial begin
        int low_cycles;
        n_checks = 0; n_pass = 0; chk_en = 0;
        bus.start = 0; bus.sel_next = 0; bus.inc = 0; bus.dec = 0; bus.confirm = 0;
        rst_n = 0;
        @(posedge clk);
        chk_en = 1;
        idle(2);
        chk("lit_rst_state", int'(bus.state), 0);
        chk("lit_rst_heap0", int'(bus.heap0), 7);
        chk("lit_rst_heap3", int'(bus.heap3), 3);
        chk("lit_rst_take",  int'(bus.take_amt), 1);
        chk("lit_rst_mstop", int'(bus.motor_stop), 1);
        chk("lit_rst_wv",    int'(bus.winner_valid), 0);
        rst_n = 1;
        idle(1);

        // Inputs other than start are ignored in IDLE
        pulse(0, 1, 1, 0, 1);
        chk("lit_idle_state", int'(bus.state), 0);

        // Single move
        pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        chk("lit_apply_state", int'(bus.state), 2);
        idle(2);
        chk("lit_move_heap0",  int'(bus.heap0), 6);
        chk("lit_move_player", int'(bus.player), 1);
        chk("lit_move_state",  int'(bus.state), 1);

        // Saturation and wrap
        pulse(1, 0, 0, 0, 0);
        repeat (10) pulse(0, 0, 1, 0, 0);
        chk("lit_inc_sat", int'(bus.take_amt), 7);
        repeat (10) pulse(0, 0, 0, 1, 0);
        chk("lit_dec_sat", int'(bus.take_amt), 1);
        repeat (4) pulse(0, 1, 0, 0, 0);
        chk("lit_sel_wrap", int'(bus.sel_heap), 0);

        // Illegal move on an emptied heap
        pulse(1, 0, 0, 0, 0);
        do_move(3, 3);
        chk("lit_heap3_empty", int'(bus.heap3), 0);
        pulse(0, 0, 0, 0, 1);
        chk("lit_illegal_hi",  int'(bus.illegal), 1);
        chk("lit_illegal_ply", int'(bus.player), 1);
        idle(1);
        chk("lit_illegal_lo",  int'(bus.illegal), 0);

        // Full game, players 0,1,0,1
        pulse(1, 0, 0, 0, 0);
        do_move(0, 6);
        do_move(1, 4);
        do_move(1, 3);
        do_move(1, 2);
        chk("lit_win_state",  int'(bus.state), 4);
        chk("lit_win_winner", int'(bus.winner), 1);
        chk("lit_win_dir",    int'(bus.motor_dir), 1);
        low_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.motor_stop == 1'b0) low_cycles++;
            if (k == 3) begin
                bus.confirm = 1;
                bus.inc = 1;
            end else begin
                bus.confirm = 0;
                bus.inc = 0;
            end
            @(negedge clk);
        end
        bus.confirm = 0; bus.inc = 0;
        chk("lit_motor_low", low_cycles, WIN_HOLD);
        chk("lit_motor_stop", int'(bus.motor_stop), 1);
        pulse(1, 0, 0, 0, 0);
        chk("lit_restart_state", int'(bus.state), 1);
        chk("lit_restart_heap1", int'(bus.heap1), 5);

        // Reset in the middle of a move
        repeat (2) pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 1);
        chk("lit_mid_apply", int'(bus.state), 2);
        #2 rst_n = 0;
        @(negedge clk);
        chk("lit_mid_state", int'(bus.state), 0);
        chk("lit_mid_heap0", int'(bus.heap0), 7);
        rst_n = 1;
        idle(1);

        // Simultaneous pulses
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 1, 1, 0);
        chk("lit_simul_sel",  int'(bus.sel_heap), 1);
        chk("lit_simul_take", int'(bus.take_amt), 1);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 1);
        chk("lit_cfm_prio_state", int'(bus.state), 2);
        chk("lit_cfm_prio_take",  int'(bus.take_amt), 2);
        idle(3);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nim_game_ctrl.md
# nim_game_ctrl

Turn-sequencing controller for the Nim game. It holds four heap counts and the current player, and accepts pre-debounced single-cycle button pulses to select a heap, set a take amount and confirm a move. It detects the end of the game and sequences the winner indication. Its heap outputs drive the four 7-segment digit inputs (`in0`..`in3`), and its motor outputs drive the step-motor `stop`/`direction` inputs as a win signal.

## Interface
- `INIT_HEAPS`, default 16'h3457: initial heap values; nibble k is heap k, so heap0=7, heap1=5, heap2=4, heap3=3.
- `WIN_HOLD`, default 32'd100_000_000: number of cycles the motor runs after a win.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse: start or restart the game.
- `sel_next`  in  1  pulse: advance the selected heap.
- `inc`  in  1  pulse: increase the take amount.
- `dec`  in  1  pulse: decrease the take amount.
- `confirm`  in  1  pulse: commit the move.
- `heap0`, `heap1`, `heap2`, `heap3`  out  4 each  current heap counts.
- `sel_heap`  out  2  index of the selected heap.
- `take_amt`  out  4  amount to remove from the selected heap.
- `player`  out  1  player to move (0 or 1).
- `winner_valid`  out  1  high while in WIN.
- `winner`  out  1  winning player; valid only when `winner_valid` is high.
- `illegal`  out  1  one-cycle pulse when a move is rejected.
- `motor_stop`  out  1  step-motor stop; 1 = stopped.
- `motor_dir`  out  1  step-motor direction; equals `winner` during WIN.
- `state`  out  3  state encoding: IDLE=0, SELECT=1, APPLY=2, CHECK=3, WIN=4.

## Operation
- **Reset values** (applied asynchronously while `rst_n`=0):
  - state=IDLE, heaps=INIT_HEAPS, sel_heap=0, take_amt=1, player=0.
  - winner=0, winner_valid=0, illegal=0, motor_stop=1, motor_dir=0, hold counter=0.
- **Input priority** when several pulses arrive in the same cycle: start > confirm > sel_next > inc > dec. Only the highest-priority pulse takes effect.
- **start**, in any state: reloads INIT_HEAPS and sets sel_heap=0, take_amt=1, player=0, winner_valid=0, motor_stop=1, counter=0, then goes to SELECT.
- **IDLE**: all inputs except start are ignored.
- **SELECT**:
  - sel_next: sel_heap+1, wrapping 3→0; take_amt resets to 1.
  - inc: take_amt+1, saturating at heap[sel_heap]; no change if that heap is 0.
  - dec: take_amt−1, saturating at 1.
  - confirm with heap[sel_heap]=0: `illegal` pulses for 1 cycle; no other change.
  - confirm with heap[sel_heap]≠0: go to APPLY.
- **APPLY**: heap[sel_heap] ← heap[sel_heap] − take_amt. The saturation rules guarantee no underflow. Go to CHECK.
- **CHECK**:
  - All four heaps 0: go to WIN; winner=player (last taker wins); motor_dir=player; motor_stop=0; counter=0.
  - Otherwise: toggle player, set take_amt=1, keep sel_heap, go to SELECT.
- **WIN**:
  - Counter increments every cycle while motor_stop=0.
  - When counter reaches WIN_HOLD−1, motor_stop←1 and the counter stops.
  - Stays in WIN until start.
- In APPLY and CHECK, every input except start is ignored.

## Timing
- A confirm sampled at edge E0 produces state=APPLY after E0.
- After E1: heap updated and state=CHECK.
- After E2: state=SELECT with player toggled, or state=WIN with winner_valid=1.
- A move therefore takes 3 cycles; the next accepted input is at E3.
- sel_next, inc, dec and the illegal-confirm response are all visible one cycle after the sampling edge.
- `motor_stop` is low for exactly WIN_HOLD cycles, starting the cycle WIN is entered.
- Asserting `rst_n` mid-operation (e.g. in APPLY) aborts the move. Outputs go to their reset values immediately, with no heap writeback.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- **Reset:** hold rst_n=0 → state=0, heaps 7/5/4/3, sel=0, take=1, motor_stop=1, winner_valid=0.
- **Single move:** start, then confirm → after 3 cycles heap0=6, player=1, take_amt=1, state=SELECT.
- **Saturation:** on heap0=7, send 10 inc → take_amt=7; then 10 dec → take_amt=1. Then 4×sel_next → sel_heap=0 (wrap).
- **Illegal move:** empty heap3 with 3 inc and confirm, then select heap3 and confirm → illegal high for 1 cycle, heaps and player unchanged.
- **Full game** (WIN_HOLD=8): clear heaps 0..3 in four moves (player 0,1,0,1) → winner=1, motor_dir=1, motor_stop=0 for exactly 8 cycles then 1. A subsequent start returns to SELECT with heaps 7/5/4/3.
- **Reset mid-move / simultaneous pulses:** assert rst_n=0 during APPLY → heap unchanged and state=IDLE. Separately, inc+dec+sel_next in one cycle → only sel_next takes effect.
